axi4_burst_mem_slave: RTL

Parametrised AXI4 slave memory model, the next generation of the team's fixed 8-entry test slave. It provides DEPTH 64-bit words with FIXED, INCR and WRAP bursts, per-byte write strobes, and echo of the request ID on R and B. It returns SLVERR for out-of-range, unsupported or malformed transactions. It sits behind the interconnect as an endpoint for bench and NoC bring-up traffic.

---
 rtl/axi4_burst_mem_slave_pkg.sv | 39 +++
 rtl/axi4_burst_addr_gen.sv | 39 +++
 rtl/axi4_burst_mem_slave.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/axi4_burst_mem_slave_pkg.sv
// Shared AXI4 widths, burst/response encodings and the slave FSM state type
// for the burst memory slave.
package axi4_burst_mem_slave_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned USER_W = 1;

  typedef logic [ID_W-1:0]   axi_id_t;
  typedef logic [ADDR_W-1:0] axi_addr_t;
  typedef logic [DATA_W-1:0] axi_data_t;
  typedef logic [STRB_W-1:0] axi_strb_t;
  typedef logic [USER_W-1:0] axi_user_t;
  typedef logic [1:0]        axi_burst_t;
  typedef logic [1:0]        axi_resp_t;

  localparam axi_burst_t BURST_FIXED = 2'b00;
  localparam axi_burst_t BURST_INCR  = 2'b01;
  localparam axi_burst_t BURST_WRAP  = 2'b10;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  localparam logic [2:0] AXSIZE_8 = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RDATA,
    ST_WDATA,
    ST_WRESP
  } state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational beat address sequencer and error classifier, shared by the
// read and write paths of the burst memory slave.
module axi4_burst_addr_gen
  import axi4_burst_mem_slave_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic [31:0] idx_i,
  input  logic [7:0]  len_i,
  input  axi_burst_t  burst_i,
  input  logic [2:0]  size_i,
  input  logic [2:0]  addr_lo_i,
  output logic [31:0] next_idx_o,
  output logic        burst_err_o,
  output logic        beat_err_o
);

  logic [31:0] inc_idx;
  logic [31:0] len_mask;

  assign inc_idx  = idx_i + 32'd1;
  assign len_mask = {24'd0, len_i};

  always_comb begin
    burst_err_o = (size_i != AXSIZE_8)
               || (burst_i == 2'b11)
               || ((burst_i == BURST_WRAP) && !wrap_len_ok(len_i))
               || (addr_lo_i != 3'd0);
    // An address below BASE_ADDR borrows into a huge index and fails here too.
    beat_err_o  = burst_err_o || (idx_i >= 32'(DEPTH));
    case (burst_i)
      BURST_FIXED: next_idx_o = idx_i;
      BURST_INCR:  next_idx_o = inc_idx;
      BURST_WRAP:  next_idx_o = (idx_i & ~len_mask) | (inc_idx & len_mask);
      default:     next_idx_o = idx_i;
    endcase
  end

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 slave memory of DEPTH 64-bit words: FIXED/INCR/WRAP bursts, byte
// strobes, ID echo, SLVERR on out-of-range or malformed transactions.
module axi4_burst_mem_slave
  import axi4_burst_mem_slave_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  axi_id_t    axi_awid_i,
  input  axi_addr_t  axi_awaddr_i,
  input  logic [7:0] axi_awlen_i,
  input  logic [2:0] axi_awsize_i,
  input  axi_burst_t axi_awburst_i,
  input  logic       axi_awlock_i,
  input  logic [3:0] axi_awcache_i,
  input  logic [2:0] axi_awprot_i,
  input  logic [3:0] axi_awqos_i,
  input  logic [3:0] axi_awregion_i,
  input  axi_user_t  axi_awuser_i,
  input  logic       axi_awvalid_i,
  output logic       axi_awready_o,
  input  axi_id_t    axi_wid_i,
  input  axi_data_t  axi_wdata_i,
  input  axi_strb_t  axi_wstrb_i,
  input  logic       axi_wlast_i,
  input  axi_user_t  axi_wuser_i,
  input  logic       axi_wvalid_i,
  output logic       axi_wready_o,
  output axi_id_t    axi_bid_o,
  output axi_resp_t  axi_bresp_o,
  output axi_user_t  axi_buser_o,
  output logic       axi_bvalid_o,
  input  logic       axi_bready_i,
  input  axi_id_t    axi_arid_i,
  input  axi_addr_t  axi_araddr_i,
  input  logic [7:0] axi_arlen_i,
  input  logic [2:0] axi_arsize_i,
  input  axi_burst_t axi_arburst_i,
  input  logic       axi_arlock_i,
  input  logic [3:0] axi_arcache_i,
  input  logic [2:0] axi_arprot_i,
  input  logic [3:0] axi_arqos_i,
  input  logic [3:0] axi_arregion_i,
  input  axi_user_t  axi_aruser_i,
  input  logic       axi_arvalid_i,
  output logic       axi_arready_o,
  output axi_id_t    axi_rid_o,
  output axi_data_t  axi_rdata_o,
  output axi_resp_t  axi_rresp_o,
  output logic       axi_rlast_o,
  output axi_user_t  axi_ruser_o,
  output logic       axi_rvalid_o,
  input  logic       axi_rready_i
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e      state_q, state_d;
  axi_id_t     id_q, id_d;
  logic [31:0] idx_q, idx_d;
  logic [7:0]  len_q, len_d;
  axi_burst_t  burst_q, burst_d;
  logic [2:0]  size_q, size_d;
  logic [2:0]  addr_lo_q, addr_lo_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic        werr_q, werr_d;
  axi_data_t   mem_q [DEPTH];
  logic        mem_we;

  logic [31:0] ar_off, aw_off, next_idx;
  logic        burst_err, beat_err, is_last;
  logic        unused_ok;

  assign ar_off  = axi_araddr_i - BASE_ADDR;
  assign aw_off  = axi_awaddr_i - BASE_ADDR;
  assign is_last = (beat_cnt_q == len_q);

  assign unused_ok = ^{axi_awlock_i, axi_awcache_i, axi_awprot_i, axi_awqos_i,
                       axi_awregion_i, axi_awuser_i, axi_wid_i, axi_wuser_i,
                       axi_arlock_i, axi_arcache_i, axi_arprot_i, axi_arqos_i,
                       axi_arregion_i, axi_aruser_i, burst_err};

  axi4_burst_addr_gen #(.DEPTH(DEPTH)) u_addr_gen (
    .idx_i       (idx_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .size_i      (size_q),
    .addr_lo_i   (addr_lo_q),
    .next_idx_o  (next_idx),
    .burst_err_o (burst_err),
    .beat_err_o  (beat_err)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (axi_arvalid_i)      state_d = ST_RDATA;
        else if (axi_awvalid_i) state_d = ST_WDATA;
      end
      ST_RDATA: if (axi_rready_i && is_last)      state_d = ST_IDLE;
      ST_WDATA: if (axi_wvalid_i && axi_wlast_i)  state_d = ST_WRESP;
      ST_WRESP: if (axi_bready_i)                 state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    axi_arready_o = (state_q == ST_IDLE);
    axi_awready_o = (state_q == ST_IDLE) && !axi_arvalid_i;
    axi_rvalid_o  = (state_q == ST_RDATA);
    axi_rid_o     = id_q;
    axi_rdata_o   = (axi_rvalid_o && !beat_err) ? mem_q[idx_q[IDX_W-1:0]] : '0;
    axi_rresp_o   = (axi_rvalid_o && beat_err) ? RESP_SLVERR : RESP_OKAY;
    axi_rlast_o   = axi_rvalid_o && is_last;
    axi_ruser_o   = '0;
    axi_wready_o  = (state_q == ST_WDATA);
    axi_bvalid_o  = (state_q == ST_WRESP);
    axi_bid_o     = id_q;
    axi_bresp_o   = (axi_bvalid_o && werr_q) ? RESP_SLVERR : RESP_OKAY;
    axi_buser_o   = '0;
  end

  always_comb begin
    id_d       = id_q;
    idx_d      = idx_q;
    len_d      = len_q;
    burst_d    = burst_q;
    size_d     = size_q;
    addr_lo_d  = addr_lo_q;
    beat_cnt_d = beat_cnt_q;
    werr_d     = werr_q;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (axi_arvalid_i) begin
          id_d       = axi_arid_i;
          idx_d      = {3'b000, ar_off[31:3]};
          len_d      = axi_arlen_i;
          burst_d    = axi_arburst_i;
          size_d     = axi_arsize_i;
          addr_lo_d  = axi_araddr_i[2:0];
          beat_cnt_d = '0;
        end else if (axi_awvalid_i) begin
          id_d       = axi_awid_i;
          idx_d      = {3'b000, aw_off[31:3]};
          len_d      = axi_awlen_i;
          burst_d    = axi_awburst_i;
          size_d     = axi_awsize_i;
          addr_lo_d  = axi_awaddr_i[2:0];
          beat_cnt_d = '0;
        end
      end
      ST_RDATA: begin
        if (axi_rready_i) begin
          idx_d      = next_idx;
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      ST_WDATA: begin
        if (axi_wvalid_i) begin
          mem_we = !beat_err;
          // Length mismatch in either direction poisons the whole burst response.
          if (beat_err || (axi_wlast_i && !is_last) || (!axi_wlast_i && is_last))
            werr_d = 1'b1;
          idx_d      = next_idx;
          beat_cnt_d = (beat_cnt_q == 8'hff) ? 8'hff : beat_cnt_q + 8'd1;
        end
      end
      ST_WRESP: if (axi_bready_i) werr_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      id_q       <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      size_q     <= '0;
      addr_lo_q  <= '0;
      beat_cnt_q <= '0;
      werr_q     <= 1'b0;
    end else begin
      id_q       <= id_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      size_q     <= size_d;
      addr_lo_q  <= addr_lo_d;
      beat_cnt_q <= beat_cnt_d;
      werr_q     <= werr_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++)
        if (axi_wstrb_i[b]) mem_q[idx_q[IDX_W-1:0]][8*b +: 8] <= axi_wdata_i[8*b +: 8];
    end
  end

endmodule
